// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// MEM pipeline stage of a 32-bit in-order core. It takes the EX/MEM bundle,
// issues at most one data-memory request per instruction, stalls the upstream
// stages while the request is outstanding, and fills the MEM/WB register.
//
// Ports
//   clk, reset (async, active-low)        clock and reset
//   ex_valid, mem_read, mem_write,        EX/MEM control bundle
//   mem_size, mem_signed, reg_write_in,
//   mem_to_reg_in, rd_in
//   alu_result, store_data                address/ALU value and store data
//   dm_req, dm_we, dm_addr, dm_wdata,     data-memory request (word aligned)
//   dm_be
//   dm_ack, dm_rdata                      data-memory completion / read word
//   stall                                 freeze upstream stages
//   wb_valid, wb_reg_write, wb_rd,        MEM/WB register
//   wb_data
//   misalign_err                          one-cycle pulse on misaligned access
//   bus_err (MEM_TIMEOUT_EN only)         one-cycle pulse on ack timeout
//
// Build option: define MEM_TIMEOUT_EN to bound the ACCESS wait to
// TIMEOUT_CYCLES cycles and add the bus_err output.
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_size,
   input  logic        mem_signed,
   input  logic        reg_write_in,
   input  logic        mem_to_reg_in,
   input  logic [4:0]  rd_in,
   input  logic [31:0] alu_result,
   input  logic [31:0] store_data,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic [3:0]  dm_be,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic        stall,
   output logic        wb_valid,
   output logic        wb_reg_write,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
`ifdef MEM_TIMEOUT_EN
   output logic        bus_err,
`endif
   output logic        misalign_err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  off_q, off_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic        we_q, we_d;
   logic        rw_q, rw_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        wb_valid_q, wb_valid_d;
   logic        wb_rw_q, wb_rw_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        mis_q, mis_d;

   logic        accept_s;
   logic        is_mem_s;
   logic        is_write_s;
   logic        misalign_s;
   logic        start_mem_s;
   logic [3:0]  be_s;
   logic [31:0] wdata_s;
   logic [31:0] lane_s;
   logic [31:0] load_s;
   logic        unused_s;

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          bus_err_q, bus_err_d;
`endif

   // mem_to_reg has no effect here: loads always write back the load result.
   assign unused_s = mem_to_reg_in;

   // A new instruction is taken in IDLE and also in RESP (the stall is already
   // released there); the reset term keeps the combinational request at zero
   // while reset is held.
   assign accept_s    = reset && ((state_q == IDLE) || (state_q == RESP));
   assign is_mem_s    = mem_read | mem_write;
   assign is_write_s  = mem_write & ~mem_read;
   assign start_mem_s = accept_s & ex_valid & is_mem_s & ~misalign_s;

   // Size decode: alignment check, byte enables and write-lane replication.
   always_comb begin
      misalign_s = 1'b0;
      be_s       = 4'b1111;
      wdata_s    = store_data;
      case (mem_size)
         2'b00: begin
            be_s    = 4'b0001 << alu_result[1:0];
            wdata_s = {4{store_data[7:0]}};
         end
         2'b01: begin
            misalign_s = alu_result[0];
            be_s       = 4'b0011 << alu_result[1:0];
            wdata_s    = {2{store_data[15:0]}};
         end
         2'b10: begin
            misalign_s = |alu_result[1:0];
         end
         default: begin
            misalign_s = 1'b1;
            be_s       = 4'b0000;
         end
      endcase
   end

   // Load lane extraction from the returned word using the latched offset.
   always_comb begin
      lane_s = dm_rdata >> {off_q, 3'b000};
      case (size_q)
         2'b00: begin
            if (signed_q) begin
               load_s = {{24{lane_s[7]}}, lane_s[7:0]};
            end else begin
               load_s = {24'd0, lane_s[7:0]};
            end
         end
         2'b01: begin
            if (signed_q) begin
               load_s = {{16{lane_s[15]}}, lane_s[15:0]};
            end else begin
               load_s = {16'd0, lane_s[15:0]};
            end
         end
         default: load_s = lane_s;
      endcase
   end

   // Memory request: straight from the inputs in the issue cycle, then from
   // the latched copy for as long as ACCESS waits for the acknowledge.
   always_comb begin
      dm_req   = 1'b0;
      dm_we    = 1'b0;
      dm_addr  = 32'd0;
      dm_wdata = 32'd0;
      dm_be    = 4'd0;
      if (start_mem_s) begin
         dm_req   = 1'b1;
         dm_we    = is_write_s;
         dm_addr  = {alu_result[31:2], 2'b00};
         dm_wdata = wdata_s;
         dm_be    = be_s;
      end else if (state_q == ACCESS) begin
         dm_req   = 1'b1;
         dm_we    = we_q;
         dm_addr  = addr_q;
         dm_wdata = wdata_q;
         dm_be    = be_q;
      end else begin
         dm_req = 1'b0;
      end
      stall = dm_req;
   end

   // Next-state, request latch and MEM/WB register update.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      off_d      = off_q;
      size_d     = size_q;
      signed_d   = signed_q;
      we_d       = we_q;
      rw_d       = rw_q;
      rd_d       = rd_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      wb_valid_d = 1'b0;
      wb_rw_d    = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      mis_d      = 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_d      = cnt_q;
      bus_err_d  = 1'b0;
`endif
      case (state_q)
         IDLE, RESP: begin
            state_d = IDLE;
            if (ex_valid && !is_mem_s) begin
               wb_valid_d = 1'b1;
               wb_rw_d    = reg_write_in;
               wb_rd_d    = rd_in;
               wb_data_d  = alu_result;
            end else if (ex_valid && misalign_s) begin
               // Rejected without touching memory; completes in one cycle.
               wb_valid_d = 1'b1;
               wb_rw_d    = 1'b0;
               wb_rd_d    = rd_in;
               wb_data_d  = alu_result;
               mis_d      = 1'b1;
            end else if (ex_valid) begin
               state_d  = ACCESS;
               addr_d   = {alu_result[31:2], 2'b00};
               off_d    = alu_result[1:0];
               size_d   = mem_size;
               signed_d = mem_signed;
               we_d     = is_write_s;
               rw_d     = reg_write_in;
               rd_d     = rd_in;
               wdata_d  = wdata_s;
               be_d     = be_s;
`ifdef MEM_TIMEOUT_EN
               cnt_d    = '0;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            if (dm_ack) begin
               state_d    = RESP;
               wb_valid_d = 1'b1;
               wb_rw_d    = rw_q & ~we_q;
               wb_rd_d    = rd_q;
               wb_data_d  = load_s;
            end else begin
`ifdef MEM_TIMEOUT_EN
               if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                  state_d    = IDLE;
                  wb_valid_d = 1'b1;
                  wb_rw_d    = 1'b0;
                  wb_rd_d    = rd_q;
                  bus_err_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
`else
               state_d = ACCESS;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         addr_q     <= 32'd0;
         off_q      <= 2'd0;
         size_q     <= 2'd0;
         signed_q   <= 1'b0;
         we_q       <= 1'b0;
         rw_q       <= 1'b0;
         rd_q       <= 5'd0;
         wdata_q    <= 32'd0;
         be_q       <= 4'd0;
         wb_valid_q <= 1'b0;
         wb_rw_q    <= 1'b0;
         wb_rd_q    <= 5'd0;
         wb_data_q  <= 32'd0;
         mis_q      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         cnt_q      <= '0;
         bus_err_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         off_q      <= off_d;
         size_q     <= size_d;
         signed_q   <= signed_d;
         we_q       <= we_d;
         rw_q       <= rw_d;
         rd_q       <= rd_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         wb_valid_q <= wb_valid_d;
         wb_rw_q    <= wb_rw_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         mis_q      <= mis_d;
`ifdef MEM_TIMEOUT_EN
         cnt_q      <= cnt_d;
         bus_err_q  <= bus_err_d;
`endif
      end
   end

   assign wb_valid     = wb_valid_q;
   assign wb_reg_write = wb_rw_q;
   assign wb_rd        = wb_rd_q;
   assign wb_data      = wb_data_q;
   assign misalign_err = mis_q;
`ifdef MEM_TIMEOUT_EN
   assign bus_err      = bus_err_q;
`endif

endmodule
